// File: rtl/mux8lut_cfg_seq_pkg.sv
// mux8lut_cfg_pkg
// Shared definitions for the MUX8LUT configuration sequencer:
//   - sequencer FSM state encoding
//   - per-instance {c1,c0} mode encodings of a MUX8LUT
//   - frame length helper (beats per frame)
package mux8lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  // {c1,c0} encodings of a single MUX8LUT instance
  localparam logic [1:0] MODE_C00 = 2'b00;
  localparam logic [1:0] MODE_C01 = 2'b01;
  localparam logic [1:0] MODE_C10 = 2'b10;
  localparam logic [1:0] MODE_C11 = 2'b11;

  // Beats needed to fill 2 config bits for each of num_mux instances
  function automatic int calc_beats(input int num_mux, input int beat_bits);
    return (2 * num_mux) / beat_bits;
  endfunction

endpackage

// File: rtl/mux8lut_cfg_seq_if.sv
// mux8lut_cfg_seq_if
// Configuration stream, commit handshake and status/live-config bundle.
//   master : cfg source (drives cfg_valid/cfg_data/cfg_last/commit_req)
//   slave  : sequencer  (drives cfg_ready/commit_ack/pending/err/ConfigBits)
// Optional: MUX8LUT_CFG_PARITY_EN adds cfg_parity (even parity over cfg_data).
interface mux8lut_cfg_seq_if #(
  parameter int NUM_MUX   = 8,
  parameter int BEAT_BITS = 4
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [BEAT_BITS-1:0]   cfg_data;
  logic                   cfg_last;
  logic                   commit_req;
  logic                   commit_ack;
  logic                   pending;
  logic                   err;
  logic [2*NUM_MUX-1:0]   ConfigBits;
`ifdef MUX8LUT_CFG_PARITY_EN
  logic                   cfg_parity;

  modport master (
    output cfg_valid, cfg_data, cfg_last, cfg_parity, commit_req,
    input  cfg_ready, commit_ack, pending, err, ConfigBits
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last, cfg_parity, commit_req,
    output cfg_ready, commit_ack, pending, err, ConfigBits
  );
`else
  modport master (
    output cfg_valid, cfg_data, cfg_last, commit_req,
    input  cfg_ready, commit_ack, pending, err, ConfigBits
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last, commit_req,
    output cfg_ready, commit_ack, pending, err, ConfigBits
  );
`endif
endinterface

// File: rtl/mux8lut_cfg_seq_shadow.sv
// mux8lut_cfg_shadow
// Beat-addressed shadow register plus the live config register it is
// copied into on commit.
//   clk, rst     : clock, async active-high reset
//   beat_we      : write beat_data into shadow slot beat_idx
//   beat_idx     : beat index within the frame
//   beat_data    : beat payload
//   discard      : clear the shadow (aborted frame)
//   commit       : copy shadow into config_bits
//   config_bits  : live MUX8LUT configuration
module mux8lut_cfg_shadow
  import mux8lut_cfg_pkg::*;
#(
  parameter int NUM_MUX   = 8,
  parameter int BEAT_BITS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 beat_we,
  input  logic [IDX_W-1:0]     beat_idx,
  input  logic [BEAT_BITS-1:0] beat_data,
  input  logic                 discard,
  input  logic                 commit,
  output logic [2*NUM_MUX-1:0] config_bits
);

  logic [2*NUM_MUX-1:0] shadow_q;

  // Discard wins over a write so an aborted frame never leaves stale beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (discard) begin
      shadow_q <= '0;
    end else if (beat_we) begin
      shadow_q[int'(beat_idx) * BEAT_BITS +: BEAT_BITS] <= beat_data;
    end
  end

  // Live config only ever moves as a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      config_bits <= {NUM_MUX{MODE_C00}};
    end else if (commit) begin
      config_bits <= shadow_q;
    end
  end

endmodule

// File: rtl/mux8lut_cfg_seq.sv
// mux8lut_cfg_seq
// Configuration sequencer for a bank of MUX8LUT frame-config muxes. Beats
// are gathered LSB-first into a shadow register; a commit handshake applies
// the complete frame atomically to ConfigBits.
//   UserCLK : block clock (rising edge)
//   RST     : asynchronous active-high reset
//   cfg     : slave side of mux8lut_cfg_seq_if (stream, commit, status,
//             live ConfigBits; bits [2i+1:2i] = {c1,c0} of instance i)
// Parameters: NUM_MUX instances, BEAT_BITS per beat; 2*NUM_MUX must be a
// multiple of BEAT_BITS.
// Optional: define MUX8LUT_CFG_PARITY_EN to check even parity per beat.
module mux8lut_cfg_seq
  import mux8lut_cfg_pkg::*;
#(
  parameter int NUM_MUX   = 8,
  parameter int BEAT_BITS = 4
) (
  input logic              UserCLK,
  input logic              RST,
  mux8lut_cfg_seq_if.slave cfg
);

  localparam int BEATS = calc_beats(NUM_MUX, BEAT_BITS);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  logic             pending_q, commit_ack_q, err_q;
  logic             ready, accept, parity_bad;
  logic             beat_we, frame_err, commit;

  // run_q holds cfg_ready low through reset and releases it on the first
  // clock edge afterwards, without needing a fourth FSM state.
  assign ready  = run_q && (state_q != HOLD);
  assign accept = cfg.cfg_valid && ready;

`ifdef MUX8LUT_CFG_PARITY_EN
  assign parity_bad = cfg.cfg_parity != (^cfg.cfg_data);
`else
  assign parity_bad = 1'b0;
`endif

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      run_q        <= 1'b0;
      pending_q    <= 1'b0;
      commit_ack_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_q        <= 1'b1;
      pending_q    <= (state_d == HOLD);
      commit_ack_q <= commit;
      err_q        <= frame_err;
    end
  end

  // In IDLE the counter is 0, so cnt_q is the shadow slot for every beat.
  // A frame is good only when cfg_last coincides with the final index.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_we   = 1'b0;
    frame_err = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (parity_bad || (cfg.cfg_last != (BEATS == 1))) begin
            frame_err = 1'b1;
          end else if (BEATS == 1) begin
            beat_we = 1'b1;
            state_d = HOLD;
          end else begin
            beat_we = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          if (parity_bad || (cfg.cfg_last != (cnt_q == LAST_IDX))) begin
            frame_err = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else if (cfg.cfg_last) begin
            beat_we = 1'b1;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            beat_we = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (cfg.commit_req) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  mux8lut_cfg_shadow #(
    .NUM_MUX   (NUM_MUX),
    .BEAT_BITS (BEAT_BITS),
    .IDX_W     (CNT_W)
  ) u_shadow (
    .clk         (UserCLK),
    .rst         (RST),
    .beat_we     (beat_we),
    .beat_idx    (cnt_q),
    .beat_data   (cfg.cfg_data),
    .discard     (frame_err),
    .commit      (commit),
    .config_bits (cfg.ConfigBits)
  );

  assign cfg.cfg_ready  = ready;
  assign cfg.pending    = pending_q;
  assign cfg.commit_ack = commit_ack_q;
  assign cfg.err        = err_q;

endmodule
